// File: rtl/qr_pkg.sv
// qr_pkg: shared constants, enums and ring helper for the finder-pattern generator
package qr_pkg;
  localparam int NPAT = 3;
  localparam int COORD_W = 10;
  localparam int SIZE_W = 5;
  localparam logic [2:0] MOD_LAST = 3'd6;
  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_SIZE = 3'd1;
  localparam logic [2:0] ADDR_PAT0 = 3'd2;
  localparam logic [2:0] ADDR_PAT1 = 3'd3;
  localparam logic [2:0] ADDR_PAT2 = 3'd4;
  localparam logic [2:0] ADDR_FRAMES = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [23:0] COLOR_BLACK = 24'h000000;
  localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
  typedef enum logic [1:0] {gsIDLE, gsACTIVE, gsHBLANK, gsVBLANK} gen_state_t;
  typedef enum logic [1:0] {rgRING0, rgRING1, rgCENTER} ring_t;
  // Chebyshev distance from the centre module picks the ring: 3 outer, 2 white gap, else core
  function automatic ring_t ring_of(input logic [2:0] mx, input logic [2:0] my);
    logic [2:0] dx, dy, d;
    dx = mx >= 3'd3 ? mx - 3'd3 : 3'd3 - mx;
    dy = my >= 3'd3 ? my - 3'd3 : 3'd3 - my;
    d = dx > dy ? dx : dy;
    return d == 3'd3 ? rgRING0 : d == 3'd2 ? rgRING1 : rgCENTER;
  endfunction
endpackage

// File: rtl/qr_axis_counter.sv
// qr_axis_counter: per-axis module tracker, state always describes the coordinate just stepped to
module qr_axis_counter
  import qr_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               restart,
  input  logic [COORD_W-1:0] nxt,
  input  logic [COORD_W-1:0] pos,
  input  logic [SIZE_W-1:0]  size,
  output logic               hit,
  output logic [2:0]         idx
);
  logic [SIZE_W-1:0] sub, last;
  assign last = size == '0 ? '0 : size - 1'b1;
  // restart drops a pattern clipped at the far edge so it never wraps around
  always_ff @(posedge clk)
    if (rst) begin
      hit <= 1'b0;
      sub <= '0;
      idx <= '0;
    end else if (step || restart) begin
      if (nxt == pos) begin
        hit <= 1'b1;
        sub <= '0;
        idx <= '0;
      end else if (restart) hit <= 1'b0;
      else if (hit && sub == last) begin
        sub <= '0;
        idx <= idx + 3'd1;
        hit <= idx != MOD_LAST;
      end else if (hit) sub <= sub + 1'b1;
    end
endmodule

// File: rtl/qr_pattern_gen.sv
// qr_pattern_gen: raster video generator drawing up to three QR finder patterns
module qr_pattern_gen
  import qr_pkg::*;
#(
  parameter int pHRES = 640,
  parameter int pVRES = 480,
  parameter int pHBLANK = 16,
  parameter int pVBLANK = 800
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic [2:0]  iADDRESS,
  input  logic        iWRITE,
  input  logic [31:0] iWRITE_DATA,
  input  logic        iREAD,
  output logic [31:0] oREAD_DATA,
  output logic [23:0] oVID_DATA,
  output logic        oVID_START,
  output logic        oVID_DATA_VALID
);
  localparam logic [15:0] H_LAST = 16'(pHRES - 1);
  localparam logic [15:0] V_LAST = 16'(pVRES - 1);
  localparam logic [15:0] HB_LAST = 16'(pHBLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(pVBLANK - 1);
  gen_state_t state;
  logic [15:0] hcnt, vcnt, fcnt;
  logic en, single;
  logic [SIZE_W-1:0] m_reg, m_sh, m_n;
  logic [NPAT-1:0] pen, pen_sh, hit_x, hit_y, blk;
  logic [COORD_W-1:0] x0 [NPAT];
  logic [COORD_W-1:0] y0 [NPAT];
  logic [COORD_W-1:0] x0_sh [NPAT];
  logic [COORD_W-1:0] y0_sh [NPAT];
  logic [COORD_W-1:0] x0_n [NPAT];
  logic [COORD_W-1:0] y0_n [NPAT];
  logic [2:0] idx_x [NPAT];
  logic [2:0] idx_y [NPAT];
  logic [31:0] pat_rd [NPAT];
  logic [31:0] rdata;
  logic line_end, frame_end, hb_end, vb_end, frame_start, x_restart, x_step;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic unused_wdata;
  assign unused_wdata = ^{iWRITE_DATA[30:26], iWRITE_DATA[15:10]};
  always_comb begin
    line_end = state == gsACTIVE && hcnt == H_LAST;
    frame_end = line_end && vcnt == V_LAST;
    hb_end = state == gsHBLANK && hcnt == HB_LAST;
    vb_end = state == gsVBLANK && hcnt == VB_LAST;
    frame_start = (state == gsIDLE && en) || (vb_end && en && !single);
    x_restart = frame_start || hb_end;
    x_step = state == gsACTIVE && !line_end;
    x_nxt = x_restart ? '0 : COORD_W'(hcnt + 16'd1);
    y_nxt = frame_start ? '0 : COORD_W'(vcnt + 16'd1);
    m_n = frame_start ? m_reg : m_sh;
  end
  // counters see the configuration that the shadows are about to take at a frame start
  for (genvar k = 0; k < NPAT; k++) begin : g_pat
    assign x0_n[k] = frame_start ? x0[k] : x0_sh[k];
    assign y0_n[k] = frame_start ? y0[k] : y0_sh[k];
    assign pat_rd[k] = {pen[k], 5'd0, y0[k], 6'd0, x0[k]};
    qr_axis_counter u_x (
      .clk(iCLK), .rst(iRESET), .step(x_step), .restart(x_restart), .nxt(x_nxt),
      .pos(x0_n[k]), .size(m_n), .hit(hit_x[k]), .idx(idx_x[k])
    );
    qr_axis_counter u_y (
      .clk(iCLK), .rst(iRESET), .step(hb_end), .restart(frame_start), .nxt(y_nxt),
      .pos(y0_n[k]), .size(m_n), .hit(hit_y[k]), .idx(idx_y[k])
    );
    assign blk[k] = pen_sh[k] && hit_x[k] && hit_y[k] && ring_of(idx_x[k], idx_y[k]) != rgRING1;
  end
  always_ff @(posedge iCLK)
    if (iRESET) begin
      state <= gsIDLE;
      hcnt <= '0;
      vcnt <= '0;
      fcnt <= '0;
      oVID_DATA <= '0;
      oVID_START <= 1'b0;
      oVID_DATA_VALID <= 1'b0;
    end else begin
      oVID_DATA_VALID <= state == gsACTIVE;
      oVID_START <= state == gsACTIVE && hcnt == '0 && vcnt == '0;
      oVID_DATA <= state != gsACTIVE || |blk ? COLOR_BLACK : COLOR_WHITE;
      if (frame_end) fcnt <= fcnt + 16'd1;
      if (frame_start) begin
        state <= gsACTIVE;
        hcnt <= '0;
        vcnt <= '0;
      end else if (line_end) begin
        state <= vcnt == V_LAST ? gsVBLANK : gsHBLANK;
        hcnt <= '0;
      end else if (hb_end) begin
        state <= gsACTIVE;
        hcnt <= '0;
        vcnt <= vcnt + 16'd1;
      end else if (vb_end) begin
        state <= gsIDLE;
        hcnt <= '0;
      end else if (state != gsIDLE) hcnt <= hcnt + 16'd1;
    end
  always_ff @(posedge iCLK)
    if (iRESET) begin
      en <= 1'b0;
      single <= 1'b0;
      m_reg <= SIZE_W'(1);
      m_sh <= SIZE_W'(1);
      pen <= '0;
      pen_sh <= '0;
      oREAD_DATA <= '0;
      for (int i = 0; i < NPAT; i++) begin
        x0[i] <= '0;
        y0[i] <= '0;
        x0_sh[i] <= '0;
        y0_sh[i] <= '0;
      end
    end else begin
      if (vb_end && single) en <= 1'b0;
      if (iWRITE && iADDRESS == ADDR_CTRL) {single, en} <= iWRITE_DATA[1:0];
      if (iWRITE && iADDRESS == ADDR_SIZE) m_reg <= iWRITE_DATA[SIZE_W-1:0];
      for (int i = 0; i < NPAT; i++)
        if (iWRITE && iADDRESS == ADDR_PAT0 + 3'(i)) begin
          pen[i] <= iWRITE_DATA[31];
          y0[i] <= iWRITE_DATA[25:16];
          x0[i] <= iWRITE_DATA[9:0];
        end
      if (frame_start) begin
        m_sh <= m_reg;
        pen_sh <= pen;
        for (int i = 0; i < NPAT; i++) begin
          x0_sh[i] <= x0[i];
          y0_sh[i] <= y0[i];
        end
      end
      if (iREAD) oREAD_DATA <= rdata;
    end
  always_comb begin
    rdata = '0;
    case (iADDRESS)
      ADDR_CTRL:   rdata = {30'd0, single, en};
      ADDR_SIZE:   rdata = {27'd0, m_reg};
      ADDR_PAT0:   rdata = pat_rd[0];
      ADDR_PAT1:   rdata = pat_rd[1];
      ADDR_PAT2:   rdata = pat_rd[2];
      ADDR_FRAMES: rdata = {16'd0, fcnt};
      ADDR_STATUS: rdata = {31'd0, state != gsIDLE};
      default:     rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_qr_pattern_gen.sv
// tb_qr_pattern_gen: line-level scoreboard bench for qr_pattern_gen on a reduced 64x48 raster
module tb_qr_pattern_gen;
  import qr_pkg::*;
  localparam int H = 64, V = 48, HB = 4, VB = 20;
  logic clk = 0, rst = 1;
  logic [2:0] addr = 0;
  logic wr_en = 0, rd_en = 0;
  logic [31:0] wdata = 0, rdata;
  logic [23:0] vdata;
  logic vstart, vvalid;
  qr_pattern_gen #(.pHRES(H), .pVRES(V), .pHBLANK(HB), .pVBLANK(VB)) dut (
    .iCLK(clk), .iRESET(rst), .iADDRESS(addr), .iWRITE(wr_en), .iWRITE_DATA(wdata),
    .iREAD(rd_en), .oREAD_DATA(rdata), .oVID_DATA(vdata), .oVID_START(vstart),
    .oVID_DATA_VALID(vvalid)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [H-1:0] blk; logic start;} line_t;
  line_t exp_q[$];
  line_t e;
  logic [H-1:0] cap [V];
  int n_cmp = 0, n_fail = 0;
  int valid_total = 0, start_total = 0, black_total = 0;
  int px = 0, gap = 0, gap0 = 0, lidx = 0;
  logic [H-1:0] cur;
  logic cur_start, bad, stray;
  int cfg_m = 1;
  bit cfg_pen [3];
  int cfg_x [3];
  int cfg_y [3];

  // monitor: assemble each active line and pop its expectation
  initial forever begin
    @(negedge clk);
    if (rst) begin
      px = 0; gap = 0; bad = 0; stray = 0;
    end else if (!vvalid) gap++;
    else begin
      valid_total++;
      start_total += int'(vstart);
      black_total += int'(vdata == COLOR_BLACK);
      if (px == 0) begin
        gap0 = gap; cur_start = vstart; cur = '0; bad = 0; stray = 0;
      end else if (vstart) stray = 1;
      cur[px] = vdata == COLOR_BLACK;
      if (vdata != COLOR_BLACK && vdata != COLOR_WHITE) bad = 1;
      gap = 0;
      px++;
      if (px == H) begin
        px = 0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL line: unexpected line got blk=%h start=%0b", cur, cur_start);
        end else begin
          e = exp_q.pop_front();
          lidx = e.start ? 0 : lidx + 1;
          if (lidx < V) cap[lidx] = cur;
          if (cur !== e.blk || cur_start !== e.start || bad || stray || (!e.start && gap0 != HB)) begin
            n_fail++;
            $display("FAIL line %0d: got blk=%h start=%0b gap=%0d badcolour=%0b stray=%0b, want blk=%h start=%0b gap=%0d",
                     lidx, cur, cur_start, gap0, bad, stray, e.blk, e.start, HB);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr_en = 1;
    @(posedge clk); #1;
    wr_en = 0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    addr = a; rd_en = 1;
    @(posedge clk); #1;
    rd_en = 0; d = rdata;
  endtask

  task automatic set_pat(input int k, input bit p, input int x, input int y);
    write_reg(3'(k + 2), {p, 5'd0, 10'(y), 6'd0, 10'(x)});
    cfg_pen[k] = p; cfg_x[k] = x; cfg_y[k] = y;
  endtask

  function automatic bit model_black(input int x, input int y, input int m, input int x0, input int y0);
    int me, dx, dy, ax, ay;
    me = m == 0 ? 1 : m;
    dx = x - x0; dy = y - y0;
    if (dx < 0 || dy < 0 || dx >= 7 * me || dy >= 7 * me) return 0;
    ax = dx / me - 3; ay = dy / me - 3;
    ax = ax < 0 ? -ax : ax;
    ay = ay < 0 ? -ay : ay;
    return (ax > ay ? ax : ay) != 2;
  endfunction

  task automatic push_frame(input int nl);
    line_t l;
    for (int y = 0; y < nl; y++) begin
      l.start = y == 0;
      l.blk = '0;
      for (int x = 0; x < H; x++)
        for (int k = 0; k < 3; k++)
          if (cfg_pen[k] && model_black(x, y, cfg_m, cfg_x[k], cfg_y[k])) l.blk[x] = 1;
      exp_q.push_back(l);
    end
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    s = 32'h1;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 6000 && s[0]; i++) read_reg(ADDR_STATUS, s);
    check({name, " reaches idle"}, 64'(s[0]), 0);
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 8000 && !vstart; i++) @(negedge clk);
    check({name, " start seen"}, 64'(vstart), 1);
  endtask

  initial begin
    logic [31:0] r;
    logic [H-1:0] hm;
    int p, v0, s0, b0;
    int runs [5];
    runs = '{4, 4, 12, 4, 4};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("reset valid", 64'(vvalid), 0);
    check("reset start", 64'(vstart), 0);
    check("reset data", 64'(vdata), 0);
    check("reset rdata", 64'(rdata), 0);
    read_reg(ADDR_CTRL, r);   check("reset ctrl", 64'(r), 0);
    read_reg(ADDR_SIZE, r);   check("reset size", 64'(r), 1);
    read_reg(ADDR_PAT0, r);   check("reset pat0", 64'(r), 0);
    read_reg(ADDR_FRAMES, r); check("reset frames", 64'(r), 0);
    read_reg(ADDR_STATUS, r); check("reset status", 64'(r), 0);

    // blank frame; EN dropped mid-frame still completes it
    v0 = valid_total; s0 = start_total; b0 = black_total;
    push_frame(V);
    write_reg(ADDR_CTRL, 32'd1);
    repeat (100) @(posedge clk);
    write_reg(ADDR_CTRL, 32'd0);
    wait_idle("blank");
    check("blank valid count", 64'(valid_total - v0), H * V);
    check("blank start count", 64'(start_total - s0), 1);
    check("blank black count", 64'(black_total - b0), 0);
    read_reg(ADDR_FRAMES, r); check("blank frames", 64'(r), 1);

    // M=4 pattern, single-shot frame
    b0 = black_total;
    write_reg(ADDR_SIZE, 32'd4); cfg_m = 4;
    set_pat(0, 1, 20, 10);
    push_frame(V);
    write_reg(ADDR_CTRL, 32'd3);
    wait_idle("m4");
    check("m4 black count", 64'(black_total - b0), 528);
    hm = '0; p = 20;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < runs[i]; j++) begin hm[p] = (i % 2) == 0; p++; end
    check("m4 centre row runs", 64'(cap[24]), 64'(hm));
    hm = '0;
    for (int x = 20; x < 48; x++) hm[x] = 1;
    check("m4 top row", 64'(cap[10]), 64'(hm));
    read_reg(ADDR_CTRL, r);   check("single en cleared", 64'(r[0]), 0);
    read_reg(ADDR_STATUS, r); check("single busy", 64'(r[0]), 0);
    read_reg(ADDR_FRAMES, r); check("m4 frames", 64'(r), 2);

    // clipping at the bottom-right corner and an off-screen pattern
    write_reg(ADDR_SIZE, 32'd3); cfg_m = 3;
    set_pat(0, 0, 0, 0);
    set_pat(1, 1, 58, 42);
    set_pat(2, 1, 100, 0);
    push_frame(V);
    write_reg(ADDR_CTRL, 32'd3);
    wait_idle("clip");
    hm = '0;
    for (int x = 58; x < 64; x++) hm[x] = 1;
    check("clip first row", 64'(cap[42]), 64'(hm));
    hm = '0;
    for (int x = 58; x < 61; x++) hm[x] = 1;
    check("clip last row", 64'(cap[47]), 64'(hm));
    check("clip no wrap row0", 64'(cap[0]), 0);
    read_reg(ADDR_PAT2, r); check("pat2 readback", 64'(r), 64'h8000_0064);

    // size change mid-frame applies only to the next frame
    b0 = black_total;
    set_pat(1, 0, 0, 0);
    set_pat(2, 0, 0, 0);
    set_pat(0, 1, 20, 10);
    write_reg(ADDR_SIZE, 32'd2); cfg_m = 2;
    push_frame(V);
    cfg_m = 5;
    push_frame(V);
    write_reg(ADDR_CTRL, 32'd1);
    wait_start("resize f1");
    repeat (20 * (H + HB)) @(posedge clk);
    write_reg(ADDR_SIZE, 32'd5);
    #5;
    wait_start("resize f2");
    repeat (500) @(posedge clk);
    write_reg(ADDR_CTRL, 32'd0);
    wait_idle("resize");
    check("resize black count", 64'(black_total - b0), 132 + 825);
    read_reg(ADDR_FRAMES, r); check("resize frames", 64'(r), 5);

    // reset pulse in the middle of line 24
    push_frame(24);
    write_reg(ADDR_CTRL, 32'd1);
    wait_start("reset run");
    repeat (24 * (H + HB) + 10) @(negedge clk);
    check("valid before reset", 64'(vvalid), 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1;
    check("valid after reset", 64'(vvalid), 0);
    check("data after reset", 64'(vdata), 0);
    rst = 0;
    check("queue drained at reset", 64'(exp_q.size()), 0);
    read_reg(ADDR_FRAMES, r); check("frames after reset", 64'(r), 0);
    read_reg(ADDR_CTRL, r);   check("ctrl after reset", 64'(r), 0);
    read_reg(ADDR_SIZE, r);   check("size after reset", 64'(r), 1);
    read_reg(ADDR_PAT0, r);   check("pat0 after reset", 64'(r), 0);
    v0 = valid_total;
    repeat (200) @(posedge clk);
    check("no partial frame", 64'(valid_total - v0), 0);
    check("queue drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/qr_pattern_gen.md
QR_PATTERN_GEN -- requirements
Module: qr_pattern_gen

Interface
REQ-001 SHALL have parameters: pHRES 640, active pixels per line; pVRES 480, active lines per frame; pHBLANK 16, idle cycles after each line; pVBLANK 800, idle cycles after each frame.
REQ-002 SHALL have ports: iCLK in 1, sole clock; iRESET in 1, reset, synchronous and active-high; one clock only.
REQ-003 SHALL have ports: iADDRESS in 3, register select; iWRITE in 1, write strobe; iWRITE_DATA in 32, write data; iREAD in 1, read strobe; oREAD_DATA out 32, read data valid one cycle after iREAD.
REQ-004 SHALL have ports: oVID_DATA out 24, RGB888 pixel; oVID_START out 1, first pixel of frame; oVID_DATA_VALID out 1, pixel qualifier.

Function
REQ-005 SHALL emit a video stream, frame = pVRES lines of pHRES pixels; valid high for every active pixel, low for pHBLANK cycles after each line and pVBLANK cycles after the last line.
REQ-006 SHALL assert oVID_START only together with oVID_DATA_VALID on pixel (0,0).
REQ-007 SHALL decode registers: 0 control {bit1 SINGLE, bit0 EN}; 1 module size M [4:0]; 2..4 pattern k=0..2 {bit31 PEN, [25:16] Y0, [9:0] X0}; 5 read-only frame counter [15:0]; 6 read-only status {bit0 BUSY}.
REQ-008 SHALL idle with valid low while EN=0; a new frame begins on the first cycle EN=1 is seen while idle.
REQ-009 SHALL finish the current frame, including pVBLANK, when EN is cleared mid-frame, then idle.
REQ-010 SHALL clear EN itself at the end of a frame when SINGLE=1.
REQ-011 SHALL copy M and patterns 0..2 into shadow registers on the idle-to-frame transition and at every frame boundary; mid-frame writes SHALL take effect only on the next frame.
REQ-012 SHALL treat M=0 as M=1.
REQ-013 SHALL draw each enabled pattern as 7x7 modules of M x M pixels with top-left at (X0,Y0): ring 0 black, ring 1 white, central 3x3 black; horizontal and vertical run lengths through the centre are 1:1:3:1:1 in M units.
REQ-014 SHALL output 24'h000000 for black and 24'hFFFFFF for white/background; overlapping patterns combine black-wins (OR of black).
REQ-015 SHALL compute module index per pattern without division: per-axis sub-module counter 0..M-1 and module counter 0..6, loaded at X0 or Y0, advanced per pixel or per line, inactive after module 6.
REQ-016 SHALL clip patterns that extend past pHRES-1 or pVRES-1; a pattern with X0>=pHRES or Y0>=pVRES draws nothing.
REQ-017 SHALL register oVID_DATA, oVID_START and oVID_DATA_VALID together (same cycle).
REQ-018 SHALL increment the frame counter (wrapping 16'hFFFF->0) on the last active pixel of every frame.
REQ-019 SHALL report BUSY=1 from the first pixel through the end of pVBLANK.

Reset
REQ-020 SHALL, on iRESET, clear oVID_DATA, oVID_START, oVID_DATA_VALID, oREAD_DATA, EN, SINGLE, PEN[0..2], all counters and the frame counter to 0, and set M=1 and X0=Y0=0; takes effect the cycle after iRESET is sampled, including mid-frame, with no partial-frame completion.

Structure
REQ-021 SHALL take from a shared package qr_pkg: register address constants, colour constants (black/white), the generator state enum (gsIDLE, gsACTIVE, gsHBLANK, gsVBLANK) and the module-ring enum.
REQ-022 SHALL instantiate sub-module qr_axis_counter (load position, size M, step strobe; outputs in-range flag and module index 0..6) twice per pattern (X and Y); the top holds the raster counters, the FSM and the register file.

Verification
REQ-023 SHALL cover: EN=1, all PEN=0 -> 640x480 frame of 24'hFFFFFF, exactly 307200 valid cycles, one oVID_START, frame counter 1.
REQ-024 SHALL cover: M=4, pattern0 (X0=100,Y0=50) -> line 50+14=64 runs from x=100: 4 black, 4 white, 12 black, 4 white, 4 black; total black pixels in frame = 24*4*4 + 9*16 = 528.
REQ-025 SHALL cover: M=3, pattern1 at X0=630,Y0=470 -> pixels clipped at x=639/y=479, no wrap onto line 0 or column 0, line length stays 640.
REQ-026 SHALL cover: M changed from 2 to 5 at line 200 -> current frame unchanged, next frame uses M=5.
REQ-027 SHALL cover: SINGLE=1,EN=1 -> exactly one frame, EN reads 0 and BUSY 0 after pVBLANK; iRESET pulsed at line 240 -> valid low next cycle, frame counter 0.
